// File: rtl/instrumented_adder_pkg.sv
// Shared constants for the ring-oscillator-instrumented adder.
// RING_DELAY_NS is only used when INSTR_ADDER_RING_DELAY_EN is defined.
package instrumented_adder_pkg;
  localparam int WIDTH_DEFAULT = 32;
  localparam int RING_DELAY_NS = 1;
endpackage

// File: rtl/instrumented_adder_ring_osc_counter.sv
// Counter clocked directly by the ring node; cleared only by the async active-low reset.
module ring_osc_counter
  import instrumented_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             ring,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge ring or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/instrumented_adder_core.sv
// Adder whose inputs/outputs close a ring oscillator; ring edges are counted over a clk window.
// Define INSTR_ADDER_RING_DELAY_EN to give the ring inversion a behavioural delay for simulation.
module instrumented_adder_core
  import instrumented_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop_b,
  input  logic             extra_inverter,
  input  logic             bypass_b,
  input  logic             control_b,
  input  logic [WIDTH-1:0] a_input_ext_bit_b,
  input  logic [WIDTH-1:0] a_input_ring_bit_b,
  input  logic [WIDTH-1:0] s_output_bit_b,
  input  logic             counter_enable,
  input  logic             counter_load,
  input  logic             force_count,
  input  logic [WIDTH-1:0] integration_time,
  input  logic [WIDTH-1:0] a_input,
  input  logic [WIDTH-1:0] b_input,
  output logic [WIDTH-1:0] sum_out,
  output logic             done,
  output logic [WIDTH-1:0] ring_osc_counter_out
);

  logic             ring_node;
  logic             ring_next;
  logic             fb;
  logic             ring_en;
  logic [WIDTH-1:0] ring_vec;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] integ_cnt;

  // Operand muxing: ring selection overrides the external a bit; b follows only when control_b=0.
  assign ring_vec = {WIDTH{ring_node}};
  assign a_eff    = (ring_vec & ~a_input_ring_bit_b)
                  | (a_input_ring_bit_b & ~a_input_ext_bit_b & a_input);
  assign b_eff    = control_b ? b_input
                  : ((ring_vec & ~a_input_ring_bit_b) | (a_input_ring_bit_b & b_input));
  assign sum_out  = a_eff + b_eff;

  assign fb        = bypass_b ? |(sum_out & ~s_output_bit_b) : ring_node;
  assign ring_next = stop_b & (extra_inverter ? fb : ~fb);

  // Deliberate combinational loop: ring_node feeds the adder and returns through fb.
`ifdef INSTR_ADDER_RING_DELAY_EN
  assign #(RING_DELAY_NS * 1ns) ring_node = ring_next;
`else
  assign ring_node = ring_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      integ_cnt <= '0;
    end else if (counter_load) begin
      integ_cnt <= integration_time;
    end else if (counter_enable && (integ_cnt != '0)) begin
      integ_cnt <= integ_cnt - WIDTH'(1);
    end
  end

  assign done    = (integ_cnt == '0);
  assign ring_en = counter_enable & (~done | force_count);

  ring_osc_counter #(
    .WIDTH (WIDTH)
  ) u_ring_osc_counter (
    .ring   (ring_node),
    .reset  (reset),
    .enable (ring_en),
    .count  (ring_osc_counter_out)
  );

endmodule

// File: tb/tb_instrumented_adder_core.sv
// Self-checking bench for instrumented_adder_core: adder, integration window, ring counter, reset.
// Ring edges are produced by toggling stop_b with a static feedback path; the free-running ring is checked only with INSTR_ADDER_RING_DELAY_EN.
module tb_instrumented_adder_core;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, stop_b, extra_inverter, bypass_b, control_b;
  logic         counter_enable, counter_load, force_count;
  logic [W-1:0] a_input_ext_bit_b, a_input_ring_bit_b, s_output_bit_b;
  logic [W-1:0] integration_time, a_input, b_input;
  logic [W-1:0] sum_out, ring_osc_counter_out;
  logic         done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instrumented_adder_core #(.WIDTH(W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .stop_b               (stop_b),
    .extra_inverter       (extra_inverter),
    .bypass_b             (bypass_b),
    .control_b            (control_b),
    .a_input_ext_bit_b    (a_input_ext_bit_b),
    .a_input_ring_bit_b   (a_input_ring_bit_b),
    .s_output_bit_b       (s_output_bit_b),
    .counter_enable       (counter_enable),
    .counter_load         (counter_load),
    .force_count          (force_count),
    .integration_time     (integration_time),
    .a_input              (a_input),
    .b_input              (b_input),
    .sum_out              (sum_out),
    .done                 (done),
    .ring_osc_counter_out (ring_osc_counter_out)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One rising ring edge when the feedback path is static and resolves to 1.
  task automatic ring_pulse();
    stop_b = 1'b1;
    #2;
    stop_b = 1'b0;
    #2;
  endtask

  function automatic logic [W-1:0] adder_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [W-1:0] ext_b, input logic [W-1:0] ring_b,
                                               input logic ctl_b, input logic r);
    logic [W-1:0] ae, be;
    for (int i = 0; i < W; i++) begin
      if (!ring_b[i])     ae[i] = r;
      else if (!ext_b[i]) ae[i] = a[i];
      else                ae[i] = 1'b0;
      be[i] = (!ctl_b && !ring_b[i]) ? r : b[i];
    end
    return ae + be;
  endfunction

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] exp_cnt;
    logic [W-1:0] ea, eb, ext_b, ring_b, mask;
    logic         ctl, r, fire, en;
    int           n, rem;

    reset = 1'b0; stop_b = 1'b0; extra_inverter = 1'b0; bypass_b = 1'b1; control_b = 1'b1;
    counter_enable = 1'b1; counter_load = 1'b1; force_count = 1'b0;
    a_input_ext_bit_b = '0; a_input_ring_bit_b = '1; s_output_bit_b = '1;
    integration_time = 32'd5; a_input = '0; b_input = '0;

    // Reset holds counters at zero even with load/enable active.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", done, 1);
    chk("reset_ring_cnt", ring_osc_counter_out, 0);
    @(negedge clk);
    counter_load = 1'b0; counter_enable = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_done", done, 1);

    a_input = 32'd5; b_input = 32'd7; #1;
    chk("add_5_7", sum_out, 32'd12);
    a_input = 32'hFFFF_FFFF; b_input = 32'd1; #1;
    chk("add_wrap", sum_out, 32'd0);

    // Random operand routing with a static ring level (ring = stop_b here).
    for (int k = 0; k < 20; k++) begin
      ea = $urandom; eb = $urandom; ext_b = $urandom; ring_b = $urandom;
      ctl = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      a_input = ea; b_input = eb; a_input_ext_bit_b = ext_b; a_input_ring_bit_b = ring_b;
      control_b = ctl; stop_b = r;
      #1;
      chk($sformatf("rand_add_%0d", k), sum_out, adder_model(ea, eb, ext_b, ring_b, ctl, r));
    end
    stop_b = 1'b0; control_b = 1'b1; a_input_ring_bit_b = '1; a_input_ext_bit_b = '0;
    #1;

    // Directed window of 10.
    @(negedge clk);
    integration_time = 32'd10; counter_load = 1'b1; counter_enable = 1'b1;
    @(posedge clk); #1;
    chk("win10_load_edge", done, 0);
    @(negedge clk);
    counter_load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("win10_edge_%0d", k), done, (k >= 10) ? 1 : 0);
    end

    @(negedge clk);
    integration_time = 32'd0; counter_load = 1'b1;
    @(posedge clk); #1;
    chk("load_zero_done", done, 1);
    @(negedge clk);
    counter_load = 1'b0;

    // Random windows with gapped enable.
    for (int run = 0; run < 3; run++) begin
      n = $urandom_range(1, 12);
      @(negedge clk);
      integration_time = W'(n); counter_load = 1'b1; counter_enable = 1'($urandom_range(0, 1));
      rem = n;
      @(posedge clk); #1;
      chk($sformatf("rwin%0d_load", run), done, 0);
      for (int c = 0; c < n + 8; c++) begin
        @(negedge clk);
        counter_load = 1'b0;
        en = ($urandom_range(0, 3) != 0);
        counter_enable = en;
        @(posedge clk);
        if (en && rem > 0) rem--;
        #1;
        chk($sformatf("rwin%0d_c%0d", run, c), done, (rem == 0) ? 1 : 0);
      end
    end

    // Ring counter driven by controlled stop_b edges while the window is open.
    @(negedge clk);
    integration_time = 32'd1000; counter_load = 1'b1; counter_enable = 1'b1;
    @(negedge clk);
    counter_load = 1'b0;
    exp_cnt = ring_osc_counter_out;
    chk("ring_start_zero", exp_cnt, 0);
    repeat (3) ring_pulse();
    exp_cnt = exp_cnt + 3;
    chk("ring_count_3", ring_osc_counter_out, exp_cnt);
    counter_enable = 1'b0;
    repeat (2) ring_pulse();
    chk("ring_hold_disabled", ring_osc_counter_out, exp_cnt);
    counter_enable = 1'b1;

    // Sum feedback through the OR of selected bits; operands do not depend on the ring.
    for (int k = 0; k < 12; k++) begin
      ea = $urandom; eb = $urandom;
      mask = ~($urandom & $urandom & $urandom);
      extra_inverter = 1'($urandom_range(0, 1));
      a_input = ea; b_input = eb; s_output_bit_b = mask;
      #1;
      fire = |((ea + eb) & ~mask);
      if (!extra_inverter) fire = ~fire;
      ring_pulse();
      if (fire) exp_cnt = exp_cnt + 1;
      chk($sformatf("fb_or_%0d", k), ring_osc_counter_out, exp_cnt);
    end
    s_output_bit_b = '1; extra_inverter = 1'b0;

    @(negedge clk);
    integration_time = 32'd0; counter_load = 1'b1;
    @(negedge clk);
    counter_load = 1'b0;
    chk("force_done_high", done, 1);
    repeat (2) ring_pulse();
    chk("no_count_when_done", ring_osc_counter_out, exp_cnt);
    force_count = 1'b1;
    repeat (3) ring_pulse();
    exp_cnt = exp_cnt + 3;
    chk("force_count", ring_osc_counter_out, exp_cnt);
    force_count = 1'b0;

    // Asynchronous reset in the middle of a window.
    @(negedge clk);
    integration_time = 32'd50; counter_load = 1'b1;
    @(negedge clk);
    counter_load = 1'b0;
    repeat (3) @(posedge clk);
    ring_pulse();
    exp_cnt = exp_cnt + 1;
    chk("pre_reset_count", ring_osc_counter_out, exp_cnt);
    chk("pre_reset_done", done, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset_done", done, 1);
    chk("midreset_ring_cnt", ring_osc_counter_out, 0);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("after_reset_done", done, 1);
    ring_pulse();
    chk("after_reset_ring_cnt", ring_osc_counter_out, 0);

`ifdef INSTR_ADDER_RING_DELAY_EN
    // Free-running ring: 2 ns period over a 100 ns window.
    @(negedge clk);
    bypass_b = 1'b0; extra_inverter = 1'b0;
    integration_time = 32'd10; counter_load = 1'b1; counter_enable = 1'b1; stop_b = 1'b1;
    @(negedge clk);
    counter_load = 1'b0;
    repeat (12) @(negedge clk);
    stop_b = 1'b0;
    #5;
    bypass_b = 1'b1;
    chk("ring_free_run_50", ((ring_osc_counter_out >= 49) && (ring_osc_counter_out <= 51)) ? 1 : 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instrumented_adder_core.md
# instrumented_adder_core

Ring-oscillator-instrumented WIDTH-bit adder that measures adder propagation delay on silicon. Selected adder input bits are driven by a free-running ring node, and selected sum bits are fed back to close the loop. A ring-clocked counter accumulates ring edges during a clk-timed integration window. It sits behind the LA/IO wrapper, which supplies all controls and operands and reads back the results.

## Interface
Clock and reset are one clock; reset is asynchronous and active-low.

Parameters:
- WIDTH, 32, operand, sum, mask and counter width.

Ports:
- clk  in  1  system clock; times the integration window.
- reset  in  1  asynchronous, active-low; clears all counters.
- stop_b  in  1  0 = ring forced static low.
- extra_inverter  in  1  1 = one additional inversion in the ring.
- bypass_b  in  1  0 = ring feedback bypasses the adder.
- control_b  in  1  0 = ring also drives selected b operand bits.
- a_input_ext_bit_b  in  WIDTH  per-bit, active-low: a bit takes a_input.
- a_input_ring_bit_b  in  WIDTH  per-bit, active-low: a bit (and b bit when control_b=0) takes the ring node.
- s_output_bit_b  in  WIDTH  per-bit, active-low: sum bit feeds back to the ring.
- counter_enable  in  1  enables the integration and ring counters.
- counter_load  in  1  loads integration_time.
- force_count  in  1  ring counter counts even when done=1.
- integration_time  in  WIDTH  integration window in clk cycles.
- a_input, b_input  in  WIDTH  external operands.
- sum_out  out  WIDTH  adder result.
- done  out  1  integration counter is zero.
- ring_osc_counter_out  out  WIDTH  ring rising-edge count.

## Operation
- Operand a, per bit i:
  - ring node if a_input_ring_bit_b[i]=0;
  - else a_input[i] if a_input_ext_bit_b[i]=0;
  - else 0.
- Operand b, per bit i: ring node if control_b=0 and a_input_ring_bit_b[i]=0; else b_input[i].
- sum_out = a_eff + b_eff, combinational, modulo 2^WIDTH; carry-out is dropped.
- Feedback f:
  - when bypass_b=1: OR of all sum_out bits whose s_output_bit_b bit is 0 (f=0 if none is selected);
  - when bypass_b=0: f is the ring node itself.
- Ring node: 0 when stop_b=0; otherwise ~f when extra_inverter=0 and f when extra_inverter=1. This is an intentional combinational loop.
- Integration counter (clk domain):
  - counter_load=1: loads integration_time; load has priority over decrement.
  - Otherwise, when counter_enable=1 and the counter is nonzero, it decrements by 1 per clk.
  - It holds at 0.
- done = (integration counter == 0), combinational.
- Ring counter (clocked on ring-node rising edge):
  - increments when counter_enable=1 and (done=0 or force_count=1);
  - wraps at 2^WIDTH;
  - is cleared only by reset.
- Enables are sampled raw in the ring domain; the ring counter is read only after stop_b=0 or done=1.

## Timing
- Reset values: integration counter 0, ring counter 0, done=1, ring_osc_counter_out=0. sum_out is combinational and has no reset value.
- Reset asserted mid-window: both counters clear immediately; done rises immediately.
- After counter_load is sampled with value N, done falls on the same edge and rises on the Nth subsequent enabled clk edge.
- N=0 loaded: done stays 1.
- counter_enable=0: both counters hold.

## Configuration
- INSTR_ADDER_RING_DELAY_EN, when defined: the ring inversion stage carries a 1 ns delay for behavioural simulation; all other logic has zero delay. In bypass mode this gives a 2 ns ring period.
- When undefined: pure zero-delay logic for synthesis. The loop then has no simulation-defined period.

## Structure
- Package instrumented_adder_pkg holds WIDTH_DEFAULT and the ring-delay constant.
- One sub-module, ring_osc_counter: the ring-clocked enabled counter with asynchronous active-low reset.

## Test plan
- Combinational adder: stop_b=0, a_input_ring_bit_b all 1s, a_input_ext_bit_b=0, a_input=5, b_input=7 -> sum_out=12. With a_input=0xFFFFFFFF and b_input=1 -> sum_out=0.
- Integration window: integration_time=10, counter_load pulsed for 1 cycle, counter_enable=1 -> done is 0 for 10 clk edges, then 1 and holds.
- Ring count (macro on): stop_b=1, bypass_b=0, extra_inverter=0, 10 ns clk, integration_time=10 -> ring_osc_counter_out=50 ±1.
- Stop and force: stop_b=0 -> counter frozen. With done=1, force_count=1 and the ring running -> counter keeps incrementing.
- Adder parity path (macro on): ring on a[0], b_input[0]=1, s_output_bit_b[0]=0, bypass_b=1:
  - extra_inverter=1 -> oscillates, counter grows;
  - extra_inverter=0 -> static, counter constant.
- Reset mid-count: assert reset low while counting -> counters 0 and done=1 immediately. Release reset -> values hold until the next load.
